mac_array_seq_ctrl: RTL and testbench

- Sequencer for a ROW x COL systolic array of mac tiles.
- Generates the west-edge 3-bit instruction: bit2 = mode (0 weight-stationary, 1 output-stationary), bit1 = execute, bit0 = load (WS) or flush (OS).
- Drives read enables and addresses for the weight and activation SRAMs, aligned to their 1-cycle read latency.
- Reports busy/done to the top-level core controller.

---
 rtl/mac_array_seq_ctrl_if.sv | 28 ++
 rtl/mac_array_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mac_array_seq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_seq_ctrl_if.sv
// Core-controller / SRAM-side bundle for the systolic-array sequencer.
// master = core controller side, slave = sequencer side.
interface mac_array_seq_ctrl_if #(
    parameter int addr_bw = 11,
    parameter int k_bw    = 11
);
    logic               start;
    logic               mode;
    logic [k_bw-1:0]    num_k;
    logic               stall;
    logic               w_ren;
    logic [addr_bw-1:0] w_addr;
    logic               a_ren;
    logic [addr_bw-1:0] a_addr;
    logic [2:0]         inst_w;
    logic               busy;
    logic               done;

    modport master (
        output start, mode, num_k, stall,
        input  w_ren, w_addr, a_ren, a_addr, inst_w, busy, done
    );

    modport slave (
        input  start, mode, num_k, stall,
        output w_ren, w_addr, a_ren, a_addr, inst_w, busy, done
    );
endinterface

// File: rtl/mac_array_seq_ctrl.sv
// Sequencer for a ROW x COL systolic MAC array: SRAM read issue
// plus west-edge instruction stream, one register stage behind the reads.
module mac_array_seq_ctrl #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int addr_bw = 11,
    parameter int k_bw    = 11
) (
    input logic                clk,
    input logic                reset,
    mac_array_seq_ctrl_if.slave bus
);
    localparam int CW = (addr_bw > k_bw) ? addr_bw : k_bw;

    typedef enum logic [2:0] {
        IDLE, LOAD, EXEC, DRAIN, FLUSH, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               mode_r, mode_nxt;
    logic [k_bw-1:0]    num_k_r, num_k_nxt;
    logic               hold, accept;

    logic               w_ren_q, a_ren_q, busy_q, done_q;
    logic [addr_bw-1:0] w_addr_q, a_addr_q;
    logic [2:0]         inst_iss, inst_w_q;

    logic               w_ren_nxt, a_ren_nxt, busy_nxt, done_nxt;
    logic [addr_bw-1:0] w_addr_nxt, a_addr_nxt;
    logic [2:0]         iss_nxt, inst_w_nxt;
    logic [CW-1:0]      k_last;

    assign k_last = CW'(num_k_r) - CW'(1);

    // state/cnt name the slot whose reads are presented this cycle;
    // a stalled edge holds the slot and presents a bubble instead
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        mode_nxt  = mode_r;
        num_k_nxt = num_k_r;
        accept    = 1'b0;
        hold      = bus.stall && (state != IDLE) && (state != DONE);
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.start) begin
                    accept    = 1'b1;
                    mode_nxt  = bus.mode;
                    num_k_nxt = bus.num_k;
                    if (!bus.mode)
                        state_nxt = LOAD;
                    else if (bus.num_k == '0)
                        state_nxt = DRAIN;
                    else
                        state_nxt = EXEC;
                end
            end
            LOAD: begin
                if (cnt == CW'(COL - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = (num_k_r == '0) ? DRAIN : EXEC;
                end
            end
            EXEC: begin
                if (cnt == k_last) begin
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == CW'(ROW + COL - 2)) begin
                    cnt_nxt   = '0;
                    state_nxt = mode_r ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                if (cnt == CW'(ROW - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
        if (hold) begin
            state_nxt = state;
            cnt_nxt   = cnt;
        end
    end

    always_comb begin
        w_ren_nxt  = 1'b0;
        a_ren_nxt  = 1'b0;
        w_addr_nxt = w_addr_q;
        a_addr_nxt = a_addr_q;
        iss_nxt    = {mode_nxt, 2'b00};
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = (state_nxt == DONE);
        inst_w_nxt = accept ? {bus.mode, 2'b00} : inst_iss;
        if (!hold) begin
            unique case (state_nxt)
                LOAD: begin
                    w_ren_nxt  = 1'b1;
                    w_addr_nxt = cnt_nxt[addr_bw-1:0];
                    iss_nxt    = 3'b001;
                end
                EXEC: begin
                    a_ren_nxt  = 1'b1;
                    a_addr_nxt = cnt_nxt[addr_bw-1:0];
                    if (mode_nxt) begin
                        w_ren_nxt  = 1'b1;
                        w_addr_nxt = cnt_nxt[addr_bw-1:0];
                    end
                    iss_nxt = {mode_nxt, 2'b10};
                end
                FLUSH:   iss_nxt = 3'b101;
                default: iss_nxt = {mode_nxt, 2'b00};
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mode_r   <= 1'b0;
            num_k_r  <= '0;
            w_ren_q  <= 1'b0;
            a_ren_q  <= 1'b0;
            w_addr_q <= '0;
            a_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            inst_iss <= 3'b000;
            inst_w_q <= 3'b000;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mode_r   <= mode_nxt;
            num_k_r  <= num_k_nxt;
            w_ren_q  <= w_ren_nxt;
            a_ren_q  <= a_ren_nxt;
            w_addr_q <= w_addr_nxt;
            a_addr_q <= a_addr_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            inst_iss <= iss_nxt;
            inst_w_q <= inst_w_nxt;
        end
    end

    assign bus.w_ren  = w_ren_q;
    assign bus.w_addr = w_addr_q;
    assign bus.a_ren  = a_ren_q;
    assign bus.a_addr = a_addr_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.inst_w = inst_w_q;
endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// Randomized bench for mac_array_seq_ctrl against a slot-list model
// built from the phase lengths (LOAD/EXEC/DRAIN/FLUSH/DONE).
module tb_mac_array_seq_ctrl;
    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int AW  = 11;
    localparam int KW  = 11;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] prev_iss;
    int   exp_wa, exp_aa;

    typedef struct {
        bit         wr;
        bit         ar;
        int         wa;
        int         aa;
        logic [2:0] inst;
        bit         dn;
    } slot_t;

    slot_t q[$];

    mac_array_seq_ctrl_if #(.addr_bw(AW), .k_bw(KW)) bus ();

    mac_array_seq_ctrl #(
        .ROW(ROW), .COL(COL), .addr_bw(AW), .k_bw(KW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [2:0] inst);
        chk({tag, "_w_ren"}, 32'(bus.w_ren), 0);
        chk({tag, "_a_ren"}, 32'(bus.a_ren), 0);
        chk({tag, "_w_addr"}, 32'(bus.w_addr), exp_wa);
        chk({tag, "_a_addr"}, 32'(bus.a_addr), exp_aa);
        chk({tag, "_inst_w"}, 32'(bus.inst_w), 32'(inst));
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    function automatic int base_len(input bit m, input int k);
        return m ? k + ROW + COL - 1 + ROW + 1
                 : COL + k + ROW + COL - 1 + 1;
    endfunction

    function automatic slot_t mk(input bit wr, input bit ar, input int wa,
                                 input int aa, input logic [2:0] inst,
                                 input bit dn);
        slot_t s;
        s.wr = wr; s.ar = ar; s.wa = wa; s.aa = aa;
        s.inst = inst; s.dn = dn;
        return s;
    endfunction

    task automatic build(input bit m, input int k);
        q.delete();
        if (!m)
            for (int i = 0; i < COL; i++)
                q.push_back(mk(1, 0, i, 0, 3'b001, 0));
        for (int i = 0; i < k; i++)
            q.push_back(mk(m, 1, i % (1 << AW), i % (1 << AW), {m, 2'b10}, 0));
        for (int i = 0; i < ROW + COL - 1; i++)
            q.push_back(mk(0, 0, 0, 0, {m, 2'b00}, 0));
        if (m)
            for (int i = 0; i < ROW; i++)
                q.push_back(mk(0, 0, 0, 0, 3'b101, 0));
        q.push_back(mk(0, 0, 0, 0, {m, 2'b00}, 1));
    endtask

    task automatic do_run(input bit m, input int k, input int pct,
                          input int st_from, input int st_len,
                          input int exp_done, input int abort_at);
        int    idx = 0;
        int    c = 0;
        int    bubbles = 0;
        bit    bub = 0;
        bit    stl, e_wr, e_ar, e_dn;
        logic [2:0] iss;
        slot_t s;
        build(m, k);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.num_k = KW'(k);
        bus.stall = 1'($urandom_range(0, 1));
        prev_iss  = {m, 2'b00};
        forever begin
            @(posedge clk);
            #1;
            c++;
            bus.start = ($urandom_range(0, 7) == 0);
            if (c > 3000) begin
                chk("timeout", c, 0);
                bus.start = 1'b0;
                bus.stall = 1'b0;
                return;
            end
            if (abort_at == c) begin
                #3 reset = 1'b1;
                #1;
                exp_wa = 0;
                exp_aa = 0;
                check_idle("async_rst", 3'b000);
                @(posedge clk);
                #2 reset = 1'b0;
                bus.start = 1'b0;
                bus.stall = 1'b0;
                repeat (ROW + COL + 4) begin
                    @(posedge clk);
                    #1;
                    check_idle("post_abort", 3'b000);
                end
                return;
            end
            if (bub) begin
                e_wr = 0; e_ar = 0; e_dn = 0;
                iss = {m, 2'b00};
            end else begin
                s = q[idx];
                e_wr = s.wr; e_ar = s.ar; e_dn = s.dn;
                iss = s.inst;
                if (s.wr) exp_wa = s.wa;
                if (s.ar) exp_aa = s.aa;
            end
            chk("w_ren", 32'(bus.w_ren), 32'(e_wr));
            chk("a_ren", 32'(bus.a_ren), 32'(e_ar));
            chk("w_addr", 32'(bus.w_addr), exp_wa);
            chk("a_addr", 32'(bus.a_addr), exp_aa);
            chk("inst_w", 32'(bus.inst_w), 32'(prev_iss));
            chk("busy", 32'(bus.busy), 1);
            chk("done", 32'(bus.done), 32'(e_dn));
            prev_iss = iss;
            if (e_dn) begin
                chk("run_len", c, base_len(m, k) + bubbles);
                if (exp_done >= 0)
                    chk("done_cycle", c, exp_done);
                bus.start = 1'b1;
                bus.stall = 1'b1;
                @(posedge clk);
                #1;
                check_idle("after_done", prev_iss);
                bus.start = 1'b0;
                bus.stall = 1'b0;
                return;
            end
            if (st_len > 0)
                stl = (c >= st_from) && (c < st_from + st_len);
            else
                stl = ($urandom_range(0, 99) < pct);
            bus.stall = stl;
            if (stl) begin
                bub = 1;
                bubbles++;
            end else begin
                bub = 0;
                idx++;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.num_k = '0;
        bus.stall = 1'b0;
        exp_wa    = 0;
        exp_aa    = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset", 3'b000);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle("idle", 3'b000);

        do_run(0, 3, 0, 0, 0, 15, -1);
        do_run(1, 2, 0, 0, 0, 14, -1);
        do_run(0, 3, 0, 6, 3, 18, -1);
        do_run(0, 0, 0, 0, 0, 12, -1);
        do_run(1, 0, 0, 0, 0, 12, -1);
        do_run(0, 3, 0, 0, 0, -1, 10);
        do_run(0, 3, 0, 0, 0, 15, -1);

        for (int r = 0; r < 24; r++)
            do_run(1'($urandom_range(0, 1)), $urandom_range(0, 9),
                   25, 0, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
